// File: rtl/d3s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d3s_pkg
// Description : Shared constants, timestamp record and phase-wrap helper for
//               the revolution-frequency timestamp generator.
// Revision    : 1.0 - initial release
// ============================================================================
package d3s_pkg;

    localparam int unsigned c_phase_bits   = 14;
    localparam int unsigned c_lanes        = 4;
    localparam int unsigned c_ns_per_cycle = 8;
    localparam logic [c_phase_bits-1:0] c_half_turn = 14'd8192;

    typedef logic [c_phase_bits-1:0] phase_t;

    // 64-bit timestamp record as stored in the queue
    typedef struct packed {
        logic [31:0] tai;
        logic [31:0] nsec;
    } ts_t;

    // A wrap is a downward jump of at least half a turn between two samples
    function automatic logic is_wrap(input phase_t prev, input phase_t cur);
        return (prev > cur) && ((prev - cur) >= c_half_turn);
    endfunction

endpackage
`default_nettype wire

// File: rtl/d3s_frev_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module      : d3s_frev_ts_fifo
// Description : Synchronous FIFO for timestamps. No write-to-read bypass; a
//               push on a full queue is accepted only together with a pop.
//               Data output reads zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module d3s_frev_ts_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned     c_cw       = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_full_cnt = c_cw'(DEPTH);

    logic [c_cw-1:0]  r_count;
    logic             w_do_pop;
    logic             w_do_push;
    logic [WIDTH-1:0] w_head;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_cnt);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_empty ? '0 : w_head;

    // Occupancy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_do_push && !w_do_pop) begin
            r_count <= r_count + c_cw'(1);
        end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - c_cw'(1);
        end
    end

    if (DEPTH == 1) begin : g_single
        logic [WIDTH-1:0] r_hold;

        // The lone holding register takes every accepted push
        always_ff @(posedge clk) begin
            if (w_do_push) begin
                r_hold <= i_data;
            end
        end

        assign w_head = r_hold;
    end else begin : g_ram
        localparam int unsigned c_aw = $clog2(DEPTH);

        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [c_aw-1:0]  r_wr_ptr;
        logic [c_aw-1:0]  r_rd_ptr;

        // Storage write; on a full queue with pop the slot being read is reused
        always_ff @(posedge clk) begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
            end
        end

        // Read/write pointers, power-of-two depth wraps naturally
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) begin
                    r_wr_ptr <= r_wr_ptr + c_aw'(1);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_aw'(1);
                end
            end
        end

        assign w_head = r_mem[r_rd_ptr];
    end

endmodule
`default_nettype wire

// File: rtl/d3s_frev_ts_gen.sv
`default_nettype none
// ============================================================================
// Module      : d3s_frev_ts_gen
// Description : Detects phase wraps in four 2 ns phase lanes, timestamps every
//               g_harmonic-th wrap with WR time and queues the result.
//               Pipeline: input register, wrap detect/encode, harmonic
//               counter + queue push. Macro D3S_FREV_TS_FIFO_EN selects a
//               g_fifo_depth queue; otherwise a single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module d3s_frev_ts_gen
    import d3s_pkg::*;
#(
    parameter int unsigned g_harmonic   = 1,
    parameter int unsigned g_fifo_depth = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            enable_i,
    input  logic [c_lanes*c_phase_bits-1:0] phase_i,
    input  logic                            phase_valid_i,
    input  logic                            tm_time_valid_i,
    input  logic [31:0]                     tm_tai_i,
    input  logic [27:0]                     tm_cycles_i,
    output logic [31:0]                     frev_ts_tai_o,
    output logic [31:0]                     frev_ts_nsec_o,
    output logic                            frev_ts_valid_o,
    input  logic                            frev_ts_ready_i,
    output logic                            overflow_o
);

    localparam int unsigned c_lane_w   = $clog2(c_lanes);
    localparam logic [7:0]  c_harm_max = 8'(g_harmonic - 1);
`ifdef D3S_FREV_TS_FIFO_EN
    localparam int unsigned c_q_depth  = g_fifo_depth;
`else
    // Single holding register; g_fifo_depth has no effect on its size
    localparam int unsigned c_q_depth  = (g_fifo_depth > 0) ? 1 : 1;
`endif

    logic [c_lanes*c_phase_bits-1:0] r_s1_phase;
    logic                            r_s1_pvld;
    logic                            r_s1_tvld;
    logic                            r_s1_en;
    logic [31:0]                     r_s1_tai;
    logic [27:0]                     r_s1_cycles;

    phase_t                w_lane [c_lanes];
    logic [c_lanes-1:0]    w_wrap;
    logic [c_lane_w-1:0]   w_lane_sel;
    logic                  w_hit;
    phase_t                r_last_lane3;
    logic                  r_last_vld;

    logic                  r_s2_evt;
    logic                  r_s2_en;
    ts_t                   r_s2_ts;

    logic [7:0]            r_wrap_cnt;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    ts_t                   w_head;
    logic                  r_overflow;

    // Stage 1: register all inputs; reset drops any in-flight sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1_phase  <= '0;
            r_s1_pvld   <= 1'b0;
            r_s1_tvld   <= 1'b0;
            r_s1_en     <= 1'b0;
            r_s1_tai    <= '0;
            r_s1_cycles <= '0;
        end else begin
            r_s1_phase  <= phase_i;
            r_s1_pvld   <= phase_valid_i;
            r_s1_tvld   <= tm_time_valid_i;
            r_s1_en     <= enable_i;
            r_s1_tai    <= tm_tai_i;
            r_s1_cycles <= tm_cycles_i;
        end
    end

    // Wrap detection per lane pair and earliest-lane priority encode
    always_comb begin
        w_wrap     = '0;
        w_lane_sel = '0;
        for (int k = 0; k < c_lanes; k++) begin
            w_lane[k] = r_s1_phase[k*c_phase_bits +: c_phase_bits];
        end
        w_wrap[0] = r_last_vld && is_wrap(r_last_lane3, w_lane[0]);
        for (int k = 1; k < c_lanes; k++) begin
            w_wrap[k] = is_wrap(w_lane[k-1], w_lane[k]);
        end
        for (int k = c_lanes - 1; k >= 0; k--) begin
            if (w_wrap[k]) begin
                w_lane_sel = c_lane_w'(k);
            end
        end
        w_hit = r_s1_pvld && r_s1_tvld && r_s1_en && (w_wrap != '0);
    end

    // Lane 3 of the last valid cycle; an invalid cycle breaks the chain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_vld   <= 1'b0;
            r_last_lane3 <= '0;
        end else if (r_s1_pvld) begin
            r_last_vld   <= 1'b1;
            r_last_lane3 <= w_lane[c_lanes-1];
        end else begin
            r_last_vld   <= 1'b0;
        end
    end

    // Stage 2: register the event and its timestamp
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s2_evt <= 1'b0;
            r_s2_en  <= 1'b0;
            r_s2_ts  <= '0;
        end else begin
            r_s2_evt     <= w_hit;
            r_s2_en      <= r_s1_en;
            r_s2_ts.tai  <= r_s1_tai;
            r_s2_ts.nsec <= 32'(r_s1_cycles) * c_ns_per_cycle
                          + 32'({w_lane_sel, 1'b0});
        end
    end

    assign w_push = r_s2_en && r_s2_evt && (r_wrap_cnt == c_harm_max);
    assign w_pop  = frev_ts_valid_o && frev_ts_ready_i;

    // Stage 3: harmonic divider, held at zero while disabled
    always_ff @(posedge clk_i) begin
        if (rst_i || !r_s2_en) begin
            r_wrap_cnt <= '0;
        end else if (r_s2_evt) begin
            r_wrap_cnt <= (r_wrap_cnt == c_harm_max) ? 8'd0 : r_wrap_cnt + 8'd1;
        end
    end

    // Sticky flag for an event dropped on a full queue
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    d3s_frev_ts_fifo #(
        .DEPTH (c_q_depth),
        .WIDTH (64)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  (r_s2_ts),
        .i_pop   (frev_ts_ready_i),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign frev_ts_valid_o = ~w_empty;
    assign frev_ts_tai_o   = w_head.tai;
    assign frev_ts_nsec_o  = w_head.nsec;
    assign overflow_o      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_d3s_frev_ts_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_d3s_frev_ts_gen
// Description : Self-checking bench for d3s_frev_ts_gen with harmonic 1 and 5
//               instances, directed scenarios and a randomized run against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d3s_frev_ts_gen;

`ifdef D3S_FREV_TS_FIFO_EN
    localparam int c_depth = 4;
`else
    localparam int c_depth = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        pv = 1'b0;
    logic        tv = 1'b0;
    logic        ready = 1'b0;
    logic [55:0] phase = '0;
    logic [31:0] tai = '0;
    logic [27:0] cyc = '0;

    logic [31:0] tai1, nsec1, tai5, nsec5;
    logic        v1, v5, ovf1, ovf5;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state, index 0 = harmonic 1, index 1 = harmonic 5
    int          hm [2];
    logic [63:0] mq [2][8];
    int          mh [2];
    int          mn [2];
    int          mcnt [2];
    bit          movf [2];
    bit          dv [2][3];
    logic [63:0] dd [2][3];
    bit          m_lv;
    int          m_l3;

    always #4 clk = ~clk;

    d3s_frev_ts_gen #(.g_harmonic(1), .g_fifo_depth(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .phase_i(phase),
        .phase_valid_i(pv), .tm_time_valid_i(tv), .tm_tai_i(tai),
        .tm_cycles_i(cyc), .frev_ts_tai_o(tai1), .frev_ts_nsec_o(nsec1),
        .frev_ts_valid_o(v1), .frev_ts_ready_i(ready), .overflow_o(ovf1)
    );

    d3s_frev_ts_gen #(.g_harmonic(5), .g_fifo_depth(4)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .phase_i(phase),
        .phase_valid_i(pv), .tm_time_valid_i(tv), .tm_tai_i(tai),
        .tm_cycles_i(cyc), .frev_ts_tai_o(tai5), .frev_ts_nsec_o(nsec5),
        .frev_ts_valid_o(v5), .frev_ts_ready_i(ready), .overflow_o(ovf5)
    );

    function automatic bit wrapped(int p, int c);
        return (p > c) && ((p - c) >= 8192);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh[i] = 0; mn[i] = 0; mcnt[i] = 0; movf[i] = 0;
            for (int j = 0; j < 3; j++) begin dv[i][j] = 0; dd[i][j] = '0; end
        end
        m_lv = 0; m_l3 = 0;
    endtask

    // One input cycle: find the earliest wrap, apply enable/harmonic rules
    task automatic model_cycle();
        int ln [4];
        int first;
        bit hit;
        logic [63:0] ts;
        first = -1;
        for (int k = 0; k < 4; k++) ln[k] = int'(phase[14*k +: 14]);
        if (pv) begin
            if (m_lv && wrapped(m_l3, ln[0])) first = 0;
            for (int k = 1; k < 4; k++)
                if (first < 0 && wrapped(ln[k-1], ln[k])) first = k;
            m_lv = 1; m_l3 = ln[3];
        end else begin
            m_lv = 0;
        end
        hit = pv && tv && en && (first >= 0);
        ts = {tai, 32'(int'(cyc) * 8 + 2 * first)};
        for (int i = 0; i < 2; i++) begin
            dv[i][0] = 0;
            if (!en) mcnt[i] = 0;
            else if (hit) begin
                if (mcnt[i] == hm[i] - 1) begin
                    dv[i][0] = 1; dd[i][0] = ts; mcnt[i] = 0;
                end else mcnt[i]++;
            end
        end
    endtask

    // Clock edge: pop, then push the event from three cycles back
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mn[i] > 0 && ready) begin mh[i] = (mh[i] + 1) % 8; mn[i]--; end
                if (dv[i][2]) begin
                    if (mn[i] < c_depth) begin
                        mq[i][(mh[i] + mn[i]) % 8] = dd[i][2]; mn[i]++;
                    end else movf[i] = 1;
                end
                dv[i][2] = dv[i][1]; dd[i][2] = dd[i][1];
                dv[i][1] = dv[i][0]; dd[i][1] = dd[i][0];
            end
        end
    endtask

    task automatic step();
        if (!rst) model_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(bit p, bit t, logic [13:0] l0, logic [13:0] l1,
                         logic [13:0] l2, logic [13:0] l3, int unsigned ta, int unsigned cy);
        pv = p; tv = t; phase = {l3, l2, l1, l0}; tai = ta; cyc = 28'(cy);
    endtask

    task automatic idle();
        pv = 0;
    endtask

    task automatic do_reset();
        rst = 1; idle(); step(); step(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1 got %b want 0", v1); end
        n_cmp++; if (v5 !== 1'b0) begin n_fail++; $display("FAIL reset_valid5 got %b want 0", v5); end
        n_cmp++; if ({tai1, nsec1} !== 64'd0) begin n_fail++; $display("FAIL reset_ts1 got %h_%h want 0", tai1, nsec1); end
        n_cmp++; if ({tai5, nsec5} !== 64'd0) begin n_fail++; $display("FAIL reset_ts5 got %h_%h want 0", tai5, nsec5); end
        n_cmp++; if (ovf1 !== 1'b0 || ovf5 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b%b want 00", ovf1, ovf5); end
    endtask

    task automatic test_ramp();
        ready = 0;
        drive(1, 1, 14'h3F00, 14'h3F80, 14'h0080, 14'h0100, 7, 1000);
        step(); idle();
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL ramp_n1 valid got %b want 0", v1); end
        step();
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL ramp_n2 valid got %b want 0", v1); end
        step();
        n_cmp++;
        if (v1 !== 1'b1 || tai1 !== 32'd7 || nsec1 !== 32'd8004) begin
            n_fail++; $display("FAIL ramp_n3 got v=%b tai=%0d nsec=%0d want v=1 tai=7 nsec=8004", v1, tai1, nsec1);
        end
        ready = 1; step(); ready = 0;
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL ramp_pop valid got %b want 0", v1); end
    endtask

    task automatic test_lane0();
        bit seen;
        drive(1, 1, 14'h3FC0, 14'h3FD0, 14'h3FE0, 14'h3FF0, 7, 1000); step();
        drive(1, 1, 14'h0010, 14'h0020, 14'h0030, 14'h0040, 7, 1001); step();
        idle(); step(); step();
        n_cmp++;
        if (v1 !== 1'b1 || nsec1 !== 32'd8008) begin
            n_fail++; $display("FAIL lane0_wrap got v=%b nsec=%0d want v=1 nsec=8008", v1, nsec1);
        end
        ready = 1; step(); ready = 0;
        drive(1, 1, 14'h3FC0, 14'h3FD0, 14'h3FE0, 14'h3FF0, 7, 1000); step();
        idle(); step();
        drive(1, 1, 14'h0010, 14'h0020, 14'h0030, 14'h0040, 7, 1001); step();
        idle();
        seen = 0;
        for (int i = 0; i < 5; i++) begin step(); if (v1 !== 1'b0) seen = 1; end
        n_cmp++; if (seen) begin n_fail++; $display("FAIL lane0_gap got event want none"); end
    endtask

    task automatic test_harmonic();
        int k1, k5;
        logic [31:0] ns5 [2];
        do_reset();
        ready = 1; k1 = 0; k5 = 0; ns5[0] = '0; ns5[1] = '0;
        for (int i = 0; i < 18; i++) begin
            if (i < 12) drive(1, 1, 14'h3F00, 14'h3F80, 14'h0080, 14'h0100, 9, 2000 + i);
            else idle();
            step();
            if (v1 === 1'b1) k1++;
            if (v5 === 1'b1) begin if (k5 < 2) ns5[k5] = nsec5; k5++; end
        end
        ready = 0;
        n_cmp++; if (k1 !== 12) begin n_fail++; $display("FAIL harm1_count got %0d want 12", k1); end
        n_cmp++; if (k5 !== 2) begin n_fail++; $display("FAIL harm5_count got %0d want 2", k5); end
        n_cmp++; if (ns5[0] !== 32'd16036) begin n_fail++; $display("FAIL harm5_first got %0d want 16036", ns5[0]); end
        n_cmp++; if (ns5[1] !== 32'd16076) begin n_fail++; $display("FAIL harm5_second got %0d want 16076", ns5[1]); end
    endtask

    task automatic test_overflow();
        do_reset();
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 14'h3F00, 14'h3F80, 14'h0080, 14'h0100, 3, 3000 + i); step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", ovf1); end
        ready = 1;
        for (int j = 0; j < c_depth; j++) begin
            n_cmp++;
            if (v1 !== 1'b1 || nsec1 !== 32'((3000 + j) * 8 + 4)) begin
                n_fail++; $display("FAIL ovf_entry%0d got v=%b nsec=%0d want v=1 nsec=%0d", j, v1, nsec1, (3000 + j) * 8 + 4);
            end
            step();
        end
        ready = 0;
        n_cmp++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got valid=%b want 0", v1); end
        n_cmp++; if (ovf1 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf1); end
    endtask

    task automatic test_no_event();
        bit seen;
        do_reset();
        ready = 0;
        drive(1, 1, 14'h0100, 14'h00F0, 14'h00E0, 14'h00D0, 5, 4000); step();
        drive(1, 0, 14'h3F00, 14'h3F80, 14'h0080, 14'h0100, 5, 4001); step();
        en = 0;
        drive(1, 1, 14'h3F00, 14'h3F80, 14'h0080, 14'h0100, 5, 4002); step();
        en = 1; idle();
        seen = 0;
        for (int i = 0; i < 5; i++) begin step(); if (v1 !== 1'b0) seen = 1; end
        n_cmp++; if (seen) begin n_fail++; $display("FAIL no_event got event want none"); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        ready = 0;
        drive(1, 1, 14'h3F00, 14'h3F80, 14'h0080, 14'h0100, 11, 5000); step();
        rst = 1; idle(); step(); rst = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (v1 !== 1'b0 || tai1 !== 32'd0 || nsec1 !== 32'd0) bad = 1;
        end
        n_cmp++; if (bad) begin n_fail++; $display("FAIL reset_mid got v=%b tai=%0d nsec=%0d want all 0", v1, tai1, nsec1); end
    endtask

    task automatic test_random();
        int ph;
        do_reset();
        ph = 0;
        for (int c = 0; c < 800; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            pv    = ($urandom_range(0, 9) != 0);
            tv    = ($urandom_range(0, 19) != 0);
            en    = ($urandom_range(0, 29) != 0);
            ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 7) == 0) begin
                phase = {24'($urandom), $urandom};
            end else begin
                for (int k = 0; k < 4; k++) begin
                    ph = (ph + int'($urandom_range(0, 3500))) % 16384;
                    phase[14*k +: 14] = 14'(ph);
                end
            end
            tai = $urandom;
            cyc = 28'($urandom_range(0, 124999999));
            step();
            n_cmp++;
            if (v1 !== (mn[0] > 0) || ovf1 !== movf[0] || (mn[0] > 0 && {tai1, nsec1} !== mq[0][mh[0]])) begin
                n_fail++;
                $display("FAIL rand_h1 cyc%0d got v=%b ovf=%b ts=%h_%h want v=%0d ovf=%0d ts=%h",
                         c, v1, ovf1, tai1, nsec1, mn[0] > 0, movf[0], mq[0][mh[0]]);
            end
            n_cmp++;
            if (v5 !== (mn[1] > 0) || ovf5 !== movf[1] || (mn[1] > 0 && {tai5, nsec5} !== mq[1][mh[1]])) begin
                n_fail++;
                $display("FAIL rand_h5 cyc%0d got v=%b ovf=%b ts=%h_%h want v=%0d ovf=%0d ts=%h",
                         c, v5, ovf5, tai5, nsec5, mn[1] > 0, movf[1], mq[1][mh[1]]);
            end
        end
        rst = 0; en = 1; ready = 0;
    endtask

    initial begin
        hm[0] = 1; hm[1] = 5;
        model_reset();
        test_reset();
        test_ramp();
        test_lane0();
        test_harmonic();
        test_overflow();
        test_no_event();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/d3s_frev_ts_gen.md
D3S_FREV_TS_GEN -- requirements
Module: d3s_frev_ts_gen

Interface
REQ-001 Parameter g_harmonic, default 1: number of phase wraps per emitted timestamp (range 1..255).
REQ-002 Parameter g_fifo_depth, default 4: timestamp queue depth (power of 2, >=2).
REQ-003 clk_i  in  1  clk_wr_ref, 125 MHz (8 ns cycle).
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 enable_i  in  1  detector enable; low holds the wrap counter at 0 and suppresses events.
REQ-006 phase_i  in  56  four 14-bit phase lanes, lane k at [14*k+:14], lane 0 earliest, 2 ns apart.
REQ-007 phase_valid_i  in  1  phase_i qualifier.
REQ-008 tm_time_valid_i  in  1  WR time valid.
REQ-009 tm_tai_i  in  32  WR TAI seconds.
REQ-010 tm_cycles_i  in  28  WR cycle count within second (0..124999999).
REQ-011 frev_ts_tai_o  out  32  timestamp seconds.
REQ-012 frev_ts_nsec_o  out  32  timestamp nanoseconds.
REQ-013 frev_ts_valid_o  out  1  timestamp available.
REQ-014 frev_ts_ready_i  in  1  consumer accepts; transfer when valid and ready both high.
REQ-015 overflow_o  out  1  sticky: an event was dropped because the queue was full.

Function
REQ-016 Stage 1 SHALL register phase_i, phase_valid_i, tm_time_valid_i, tm_tai_i, tm_cycles_i.
REQ-017 Lane pair (prev, cur) SHALL be a wrap when prev > cur and (prev - cur) >= 8192; lane 0 pairs with lane 3 of the last valid cycle.
REQ-018 Cycles with phase_valid_i low SHALL detect nothing and SHALL NOT update the stored lane 3; the first valid cycle after reset or after an invalid cycle SHALL NOT test lane 0.
REQ-019 Stage 2 SHALL priority-encode the earliest wrapping lane L; at most one wrap per cycle SHALL be counted.
REQ-020 Event timestamp: tai = registered tm_tai, nsec = registered tm_cycles*8 + 2*L; no seconds rollover (max 999999998).
REQ-021 A wrap SHALL be ignored when tm_time_valid_i or enable_i was low in its cycle.
REQ-022 Stage 3: a wrap counter (8 bit) SHALL increment per counted wrap; when it equals g_harmonic-1 the event SHALL be pushed and the counter cleared; g_harmonic=1 pushes every wrap.
REQ-023 Latency: a wrap in input cycle N SHALL be visible on the outputs at the rising edge of cycle N+3 when the queue was empty.
REQ-024 Outputs SHALL present the queue head; frev_ts_valid_o high iff queue non-empty; data stable while valid and not ready.
REQ-025 Push when full SHALL drop the new event, keep queue contents and set overflow_o; simultaneous pop and push on a full queue SHALL accept the push.
REQ-026 Push on an empty queue SHALL NOT bypass: data is readable one cycle after the push.

Reset
REQ-027 rst_i SHALL empty the queue, clear the wrap counter and the stored-lane-3 valid flag, and set frev_ts_valid_o=0, overflow_o=0, frev_ts_tai_o=0, frev_ts_nsec_o=0.
REQ-028 Reset mid-operation SHALL discard all in-flight pipeline events; no event from pre-reset input SHALL appear afterwards.

Configuration
REQ-029 Macro D3S_FREV_TS_FIFO_EN defined: queue is g_fifo_depth entries, as above.
REQ-030 Macro undefined: queue is a single holding register (depth 1); g_fifo_depth ignored; REQ-025 applies to that register.

Structure
REQ-031 Shared package d3s_pkg SHALL hold c_phase_bits=14, c_lanes=4, c_ns_per_cycle=8, c_half_turn=8192 and the 64-bit timestamp record (tai, nsec).
REQ-032 The queue SHALL be one sub-module d3s_frev_ts_fifo (sync FIFO, 64-bit, full/empty flags).

Verification
REQ-033 Ramp phase 0x3F00,0x3F80,0x0080,0x0100 at tm_tai=7, tm_cycles=1000 -> one timestamp tai=7, nsec=8004, valid at cycle N+3.
REQ-034 Lane 3 of cycle 1000=0x3FF0, lane 0 of cycle 1001=0x0010 -> nsec=8008; same with phase_valid_i low in between -> no event.
REQ-035 g_harmonic=5, 12 wraps -> exactly 2 timestamps, at wraps 5 and 10.
REQ-036 ready held low, 5 wraps, depth 4 -> first 4 queued in order, overflow_o=1; with macro undefined -> only first retained.
REQ-037 Descending phase 0x0100->0x00F0 (diff small) and tm_time_valid_i low during a true wrap -> no event.
REQ-038 rst_i asserted one cycle after a wrap -> no timestamp ever emitted for it, outputs 0.
